bus_arbiter: RTL and testbench

Two-master bus arbiter that sits directly upstream of the 32-bit 2:1 bus multiplexers. It grants the shared bus to one master at a time and drives the select line of the address/data/write-enable muxes (m_sel -> mux2_32bits .s). A hold-limit counter prevents one master from starving the other under continuous contention.

---
 rtl/bus_arbiter.sv | 98 +++++++++
 tb/tb_bus_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter that drives the select of the 32-bit 2:1 bus muxes.
// Moore FSM (IDLE/GNT0/GNT1). Every output comes from registered state, so there is
// no combinational path from req to grant. A hold counter forces a handover after
// MAX_HOLD consecutive cycles of contention. MAX_HOLD must lie in 2..2^CNT_W-1.
// Optional build macro BUS_ARB_ROUND_ROBIN_EN: when it is defined, a tie in IDLE
// goes to the master that was not served last. When it is undefined, master 0 has
// fixed priority on a tie.
module bus_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_req,
   input  logic             m1_req,
   output logic             m0_grant,
   output logic             m1_grant,
   output logic             m_sel,
   output logic [CNT_W-1:0] hold_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t state, state_nxt;
   logic   oth_req;   // the non-owning master is requesting
   logic   tie_m1;    // a tie in IDLE goes to master 1

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic last_m1;     // 1: master 1 was served last (reset value lets m0 win the first tie)

   // Record which master took the bus on every entry into a grant state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_m1 <= 1'b1;
      else if (state_nxt != state && state_nxt == GNT0)
         last_m1 <= 1'b0;
      else if (state_nxt != state && state_nxt == GNT1)
         last_m1 <= 1'b1;
   end

   assign tie_m1 = ~last_m1;
`else
   assign tie_m1 = 1'b0;
`endif

   assign oth_req = (state == GNT0) ? m1_req :
                    (state == GNT1) ? m0_req : 1'b0;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decision. Preemption applies only while the owner still requests.
   // If the owner drops req, the other master takes the bus directly.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) state_nxt = tie_m1 ? GNT1 : GNT0;
            else if (m0_req)      state_nxt = GNT0;
            else if (m1_req)      state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_req)                             state_nxt = m1_req ? GNT1 : IDLE;
            else if (m1_req && hold_cnt == HOLD_LAST) state_nxt = GNT1;
         end
         GNT1: begin
            if (!m1_req)                             state_nxt = m0_req ? GNT0 : IDLE;
            else if (m0_req && hold_cnt == HOLD_LAST) state_nxt = GNT0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Count consecutive contended cycles of the current owner. Clear on a handover or when uncontended.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hold_cnt <= '0;
      else if (state_nxt != state || state == IDLE || !oth_req)
         hold_cnt <= '0;
      else
         hold_cnt <= hold_cnt + CNT_W'(1);
   end

   // Output decode from state only
   always_comb begin
      m0_grant = (state == GNT0);
      m1_grant = (state == GNT1);
      m_sel    = (state == GNT1);
      busy     = (state == GNT0) || (state == GNT1);
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plus randomized bench for bus_arbiter. A behavioural
// owner/counter model tracks the expected outputs, and a compare process checks the
// DUT against it on every falling edge. Directed sections add literal expectations
// that pin the model itself.
module tb_bus_arbiter;
   localparam int MAX_HOLD = 16;
   localparam int CNT_W    = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             m0_req = 1'b0;
   logic             m1_req = 1'b0;
   logic             m0_grant, m1_grant, m_sel, busy;
   logic [CNT_W-1:0] hold_cnt;

   int tests = 0;
   int fails = 0;

   // Model: owner is 0 = nobody, 1 = master 0, 2 = master 1
   int own  = 0;
   int hc   = 0;
   int last = 2;

   bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .m0_req(m0_req), .m1_req(m1_req),
      .m0_grant(m0_grant), .m1_grant(m1_grant), .m_sel(m_sel),
      .hold_cnt(hold_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model, applied with the same sampling as the DUT
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         own = 0; hc = 0; last = 2;
      end else begin
         int req[3];
         int nxt, other;
         req[0] = 0; req[1] = int'(m0_req); req[2] = int'(m1_req);
         if (own == 0) begin
            if (req[1] == 1 && req[2] == 1) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
               nxt = (last == 1) ? 2 : 1;
`else
               nxt = 1;
`endif
            end else if (req[1] == 1) nxt = 1;
            else if (req[2] == 1)     nxt = 2;
            else                      nxt = 0;
            hc = 0;
         end else begin
            other = 3 - own;
            if (req[own] == 0)                            nxt = (req[other] == 1) ? other : 0;
            else if (req[other] == 1 && hc == MAX_HOLD-1) nxt = other;
            else                                          nxt = own;
            hc = (nxt == own && req[other] == 1) ? hc + 1 : 0;
         end
         if (nxt != own && nxt != 0) last = nxt;
         own = nxt;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("m0_grant", int'(m0_grant), int'(own == 1));
      chk("m1_grant", int'(m1_grant), int'(own == 2));
      chk("m_sel",    int'(m_sel),    int'(own == 2));
      chk("busy",     int'(busy),     int'(own != 0));
      chk("hold_cnt", int'(hold_cnt), hc);
      chk("one_hot",  int'(m0_grant & m1_grant), 0);
   end

   // Drive reqs just after a falling edge, then wait until the next falling edge
   task automatic cyc(input bit a, input bit b);
      m0_req = a; m1_req = b;
      @(negedge clk);
   endtask

   initial begin
      int g;
      bit r0, r1;
      #3 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_m0_grant", int'(m0_grant), 0);
      chk("rst_m_sel",    int'(m_sel), 0);
      chk("rst_hold",     int'(hold_cnt), 0);
      chk("rst_busy",     int'(busy), 0);

      // Tie-break twice, with an IDLE gap between the two ties
      cyc(1, 1);
      chk("tie1_m0", int'(m0_grant), 1);
      cyc(0, 0);
      chk("tie_gap_busy", int'(busy), 0);
      cyc(1, 1);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      chk("tie2_m1", int'(m1_grant), 1);
`else
      chk("tie2_m0", int'(m0_grant), 1);
`endif
      cyc(0, 0);

      // Single master: five request cycles give exactly five grant cycles
      g = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1);
         g += int'(m1_grant && m_sel && busy);
      end
      chk("single_len", g, 5);
      cyc(0, 0);
      chk("single_release", int'(m1_grant), 0);

      // Handover from GNT0 to GNT1 with no IDLE gap
      cyc(1, 0);
      chk("ho_m0", int'(m0_grant), 1);
      cyc(0, 1);
      chk("ho_m1", int'(m1_grant), 1);
      chk("ho_m0_off", int'(m0_grant), 0);
      chk("ho_sel", int'(m_sel), 1);
      chk("ho_hold", int'(hold_cnt), 0);
      cyc(0, 0);

      // Contention: 16 cycles each, alternating owners
      for (int i = 0; i < MAX_HOLD; i++) begin
         cyc(1, 1);
         chk("cont_m0", int'(m0_grant), 1);
         chk("cont_hold0", int'(hold_cnt), i);
      end
      for (int i = 0; i < MAX_HOLD; i++) begin
         cyc(1, 1);
         chk("cont_m1", int'(m1_grant), 1);
         chk("cont_hold1", int'(hold_cnt), i);
      end
      // Owner drops req at hold_cnt=15: master 0 takes over directly
      cyc(1, 0);
      chk("simrel_m0", int'(m0_grant), 1);
      chk("simrel_hold", int'(hold_cnt), 0);
      cyc(0, 0);

      // Reset in the middle of a GNT1 transfer with a non-zero hold count
      cyc(0, 1);
      cyc(1, 1);
      cyc(1, 1);
      cyc(1, 1);
      chk("pre_rst_hold", int'(hold_cnt), 3);
      #2 reset = 1'b1;
      #1;
      chk("arst_m1_grant", int'(m1_grant), 0);
      chk("arst_m_sel", int'(m_sel), 0);
      chk("arst_hold", int'(hold_cnt), 0);
      @(negedge clk);
      reset = 1'b0;
      cyc(1, 0);
      chk("post_rst_m0", int'(m0_grant), 1);
      cyc(0, 0);

      // Randomized phase. Reqs toggle slowly so long contention runs occur.
      r0 = 1'b0; r1 = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) r0 = ~r0;
         if ($urandom_range(0, 29) == 0) r1 = ~r1;
         m0_req = r0; m1_req = r1;
         if ($urandom_range(0, 999) == 0) begin
            #2 reset = 1'b1;
            #1;
            chk("rnd_arst_busy", int'(busy), 0);
            @(negedge clk);
            reset = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      cyc(0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety bound on run time
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
